// File: rtl/peridot_phy_rxd.sv
// peridot_phy_rxd: UART 8N1 receive PHY for the PERIDOT host bridge.
// Synchronises rxd, finds the start bit, samples each bit at mid-bit, and
// hands finished bytes to a ready/valid source. Framing and overrun errors
// come out as one-clock pulses.
// Optional build macro: PERIDOT_PHY_RXD_MAJORITY_EN (2-of-3 majority bit
// decisions and a two-sample start-edge qualifier). Ports are identical in
// both builds.
module peridot_phy_rxd #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUDRATE   = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       err_framing,
    output logic       err_overrun
);

    localparam int          BITDIV       = CLOCK_FREQUENCY / UART_BAUDRATE;
    localparam logic [11:0] CLOCK_DIVNUM = 12'(BITDIV - 1);
    localparam logic [11:0] HALF_DIVNUM  = 12'(BITDIV / 2 - 1);
`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
    // The edge qualifier costs one clock and the vote finishes one clock after
    // divider 0, so start one count early: the three votes then straddle the
    // point the single-sample build would use.
    localparam logic [11:0] START_LOAD   = HALF_DIVNUM - 12'd1;
`else
    localparam logic [11:0] START_LOAD   = HALF_DIVNUM;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t      state;
    logic [11:0] div;
    logic [3:0]  bitcount;
    logic [7:0]  shift;

    logic [1:0]  sync_q;
    logic        rxd_s;
    logic        rxd_h;
    logic        fall_edge;
    logic        in_frame;
    logic        div_zero;
    logic        bit_tick;
    logic        bit_val;

    assign rxd_s    = sync_q[1];
    assign in_frame = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign div_zero = (div == 12'd0);

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            rxd_h  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            rxd_h  <= rxd_s;
        end
    end

`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
    logic rxd_h2;
    logic smp1;
    logic smp0;
    logic pend;

    // Older history for the start qualifier, and the first two votes of each bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_h2 <= 1'b1;
            smp1   <= 1'b1;
            smp0   <= 1'b1;
            pend   <= 1'b0;
        end else begin
            rxd_h2 <= rxd_h;
            if (div == 12'd1) smp1 <= rxd_s;
            if (div_zero)     smp0 <= rxd_s;
            pend   <= in_frame && div_zero;
        end
    end

    // Start needs high followed by two consecutive lows; the bit decision
    // lands the clock after divider 0, using the live sample as third vote.
    assign fall_edge = rxd_h2 && !rxd_h && !rxd_s;
    assign bit_tick  = pend;
    assign bit_val   = (smp1 & smp0) | (smp1 & rxd_s) | (smp0 & rxd_s);
`else
    assign fall_edge = rxd_h && !rxd_s;
    assign bit_tick  = in_frame && div_zero;
    assign bit_val   = rxd_s;
`endif

    // Receiver FSM with divider, shifter and registered stream/error outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            div         <= 12'd0;
            bitcount    <= 4'd0;
            shift       <= 8'h00;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            err_framing <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_framing <= 1'b0;
            err_overrun <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (in_frame) div <= div_zero ? CLOCK_DIVNUM : div - 12'd1;

            case (state)
                ST_IDLE: begin
                    if (fall_edge) begin
                        div   <= START_LOAD;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        if (!bit_val) begin
                            bitcount <= 4'd8;
                            state    <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;   // false start, silently ignored
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift    <= {bit_val, shift[7:1]};
                        bitcount <= bitcount - 4'd1;
                        if (bitcount == 4'd1) state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (bit_val) begin
                            // A byte accepted this same clock frees the holder
                            if (!out_valid || out_ready) begin
                                out_data  <= shift;
                                out_valid <= 1'b1;
                            end else begin
                                err_overrun <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end else begin
                            err_framing <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Held-low line: wait for idle so a break gives one pulse
                    if (rxd_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peridot_phy_rxd.sv
// tb_peridot_phy_rxd: directed + randomized bench for peridot_phy_rxd at
// BITDIV=10. A bit-level line driver feeds frames; a negedge monitor collects
// transfers and error pulses; expectations come from byte-level rules.
module tb_peridot_phy_rxd;

    logic       clk;
    logic       reset_n;
    logic       rxd;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       err_framing;
    logic       err_overrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int n_fr = 0;
    int n_ov = 0;
    int rise_cyc = -1;
    int fall_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    peridot_phy_rxd #(
        .CLOCK_FREQUENCY(1000000),
        .UART_BAUDRATE  (100000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .err_framing(err_framing),
        .err_overrun(err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 2 ns after the rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(10);
        end
        rxd = stop_bit;
        tick(10);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        exp_q.delete();
        n_fr = 0;
        n_ov = 0;
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    // Monitor: transfers, error pulses, hold stability while stalled
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) rx_q.push_back(out_data);
            if (err_framing) n_fr++;
            if (err_overrun) n_ov++;
            if (err_framing || err_overrun)
                check("err_exclusive", 32'(err_framing & err_overrun), 32'd0);
            if (out_valid && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] held;
        int k;
        int lat;

        reset_n   = 1'b0;
        rxd       = 1'b1;
        out_ready = 1'b1;
        tick(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_errs", 32'({err_framing, err_overrun}), 32'd0);
        reset_n = 1'b1;
        tick(5);

        // Reset mid-frame after four data bits, then a clean A5
        clear_obs();
        rxd = 1'b0;
        tick(10);
        b = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            tick(10);
        end
        reset_n = 1'b0;
        tick(2);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'h00);
        check("midrst_errs", 32'({err_framing, err_overrun}), 32'd0);
        rxd = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(30);
        send_byte(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        tick(10);
        compare_q("reset");
        check("reset_nfr", 32'(n_fr), 32'd0);
        check("reset_nov", 32'(n_ov), 32'd0);

        // Basic byte and latency from pin fall to out_valid
        clear_obs();
        rise_cyc = -1;
        fall_cyc = cyc;
        send_byte(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        tick(10);
        compare_q("basic");
        lat = rise_cyc - fall_cyc;
        check("basic_latency_in_97_99", 32'((lat >= 97) && (lat <= 99)), 32'd1);

        // Back-to-back directed then random bytes, no idle between frames
        clear_obs();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < exp_q.size(); i++) send_byte(exp_q[i], 1'b1);
        tick(10);
        compare_q("b2b");
        check("b2b_nfr", 32'(n_fr), 32'd0);
        check("b2b_nov", 32'(n_ov), 32'd0);

        // Overrun: stalled sink keeps the first byte, later bytes are dropped
        clear_obs();
        out_ready = 1'b0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        tick(10);
        check("ovr_nov", 32'(n_ov), 32'd1);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_data", 32'(out_data), 32'h12);
        check("ovr_none_taken", 32'(rx_q.size()), 32'd0);
        out_ready = 1'b1;
        tick(5);
        exp_q.push_back(8'h12);
        compare_q("ovr");
        check("ovr_valid_clr", 32'(out_valid), 32'd0);

        // Randomized overrun: k bytes into a stalled sink
        clear_obs();
        out_ready = 1'b0;
        k = $urandom_range(2, 4);
        held = 8'h00;
        for (int i = 0; i < k; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 0) held = b;
            send_byte(b, 1'b1);
        end
        tick(10);
        check("rovr_nov", 32'(n_ov), 32'(k - 1));
        check("rovr_data", 32'(out_data), 32'(held));
        out_ready = 1'b1;
        tick(5);
        exp_q.push_back(held);
        compare_q("rovr");

        // Framing error followed by a long break, then a good byte
        clear_obs();
        send_byte(8'hC3, 1'b0);
        rxd = 1'b0;
        tick(500);
        rxd = 1'b1;
        tick(10);
        send_byte(8'h81, 1'b1);
        tick(10);
        exp_q.push_back(8'h81);
        compare_q("frm");
        check("frm_nfr", 32'(n_fr), 32'd1);
        check("frm_nov", 32'(n_ov), 32'd0);

        // Short low glitch on an idle line is a false start
        clear_obs();
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(150);
        compare_q("glitch");
        check("glitch_errs", 32'(n_fr + n_ov), 32'd0);

`ifdef PERIDOT_PHY_RXD_MAJORITY_EN
        // 1-clk low glitch at mid-bit of data bit 3 of FF is outvoted
        clear_obs();
        rxd = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rxd = 1'b1;
            if (i == 3) begin
                tick(5);
                rxd = 1'b0;
                tick(1);
                rxd = 1'b1;
                tick(4);
            end else begin
                tick(10);
            end
        end
        rxd = 1'b1;
        tick(20);
        exp_q.push_back(8'hFF);
        compare_q("maj_glitch");
        check("maj_glitch_errs", 32'(n_fr + n_ov), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/peridot_phy_rxd.md
Name: peridot_phy_rxd

Overview:
- UART receive PHY for the PERIDOT host bridge; counterpart of the UART sender PHY on the same link.
- Samples asynchronous `rxd`, detects start bit, recovers 8N1 frames LSB-first at mid-bit.
- Presents each byte on a ready/valid streaming source toward the host-bridge packet layer.
- Flags framing and overrun errors as single-cycle pulses.

Parameters:
- CLOCK_FREQUENCY, 50000000, `clk` frequency in Hz.
- UART_BAUDRATE, 115200, line rate in bit/s.
- Derived: BITDIV = CLOCK_FREQUENCY/UART_BAUDRATE (integer divide).
  - CLOCK_DIVNUM = BITDIV-1.
  - HALF_DIVNUM = BITDIV/2-1.
  - Legal range 8 ≤ BITDIV ≤ 4096 (12-bit divider); out-of-range is unsupported.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rxd  in  1  UART line, asynchronous, idle high.
- out_ready  in  1  sink ready.
- out_valid  out  1  byte available.
- out_data  out  8  received byte.
- err_framing  out  1  one-clk pulse: stop bit sampled low.
- err_overrun  out  1  one-clk pulse: byte completed while previous byte still held.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, divider=0, bitcount=0, shift=0.
  - Synchroniser flops = 1.
  - out_valid=0, out_data=8'h00, err_framing=0, err_overrun=0.
- Input: `rxd` passes a 2-flop synchroniser, then a 1-flop history register. A falling edge is history=1 and current=0.
- IDLE:
  - On a falling edge: load divider with HALF_DIVNUM, go to START.
- START:
  - Divider decrements each clk.
  - At 0, sample: low → load CLOCK_DIVNUM, bitcount=8, go to DATA. High → false start, return to IDLE with no error.
- DATA:
  - At each divider 0: shift sample into shift[7] (right shift, LSB first), reload CLOCK_DIVNUM, decrement bitcount.
  - When bitcount reaches 0, go to STOP.
- STOP, at divider 0:
  - Sample high and out_valid=0 → out_data<=shift, out_valid<=1, go to IDLE.
  - Sample high and out_valid=1 and out_ready=0 → byte dropped, err_overrun pulse, go to IDLE.
  - Sample high and out_valid=1 and out_ready=1 in the same cycle → the handshake completes and the new byte loads (out_valid stays 1). No overrun.
  - Sample low → err_framing pulse, byte discarded, go to BREAK.
- BREAK: wait until synchronised `rxd`=1, then go to IDLE. A held-low break line yields exactly one framing pulse.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_valid clears the cycle after the transfer unless a new byte loads that same cycle.
  - out_data is stable while out_valid=1 and unaccepted.
- A new start bit is accepted immediately in IDLE after STOP. Back-to-back frames need no extra idle time.
- Latency: out_valid rises 3 + (HALF_DIVNUM+1) + 9×BITDIV clocks (±1) after the `rxd` pin falls.
- err_* are registered, high exactly one clk, mutually exclusive per frame.
- Receiver state is independent of out_ready; the sink never stalls the line.

Optional Feature:
- PERIDOT_PHY_RXD_MAJORITY_EN defined:
  - Each bit decision (start, data, stop) is the 2-of-3 majority of synchronised samples at divider counts 1, 0 and the next clk.
  - The next-clk sample is taken while the divider has already reloaded; timing is otherwise unchanged.
  - The start-edge detect additionally requires 2 consecutive low samples.
- Undefined: single sample at divider 0; edge detect as above.
- Port list is identical in both builds.

Test Plan:
All scenarios use CLOCK_FREQUENCY=1000000, UART_BAUDRATE=100000 (BITDIV=10).
- Reset: reset_n low mid-frame (after 4 data bits), then release, then send 8'hA5 → only 8'hA5 appears; out_valid=0 and no err pulses during/after reset.
- Basic: send 8'h55 with out_ready=1 → one out_valid pulse with out_data=8'h55, ~97 clk after the pin falls.
- Back-to-back: send 8'h00, 8'hFF, 8'h3C with no idle and out_ready=1 → three transfers, in order, no errors.
- Overrun: out_ready=0, send 8'h12 then 8'h34 → out_data stays 8'h12, one err_overrun pulse at the second stop sample. Raising out_ready then gives exactly one transfer of 8'h12.
- Framing/break: 8'hC3 with stop bit low, then line held low 50 bit times, then 8'h81 → one err_framing pulse, no out_valid for 8'hC3, then 8'h81 received correctly.
- Glitch: 3-clk low pulse on idle line → no out_valid, no error. With PERIDOT_PHY_RXD_MAJORITY_EN, a 1-clk low glitch at mid-bit of a data 1 in 8'hFF → still 8'hFF.
